// File: rtl/lv_efuse_load_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// lv_efuse_load_ctrl_pkg
//   Shared definitions for the LV efuse load sequencer:
//     - FSM state width and state encodings
//     - CRC-8 polynomial used by the optional integrity check
//     - small elaboration-time helpers for sizing counters
//   Build option: macro LV_EFUSE_CRC_CHK_EN (consumed by the top and the
//   CRC sub-module, not by this package).
// ---------------------------------------------------------------------------
package lv_efuse_load_ctrl_pkg;

  localparam int EFUSE_FSM_ST_W = 3;

  typedef enum logic [EFUSE_FSM_ST_W-1:0] {
    EFUSE_IDLE_ST    = 3'd0,
    EFUSE_SETUP_ST   = 3'd1,
    EFUSE_STROBE_ST  = 3'd2,
    EFUSE_CAPTURE_ST = 3'd3,
    EFUSE_DONE_ST    = 3'd4,
    EFUSE_HOLD_ST    = 3'd5
  } efuse_fsm_st_e;

  localparam int         EFUSE_CRC_W     = 8;
  localparam logic [7:0] EFUSE_CRC8_POLY = 8'h07;

  function automatic int efuse_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width of a down-counter that is loaded with (cycles-1) for the longer
  // of the two programmable phases; never narrower than one bit.
  function automatic int efuse_tmr_w(input int setup_cyc, input int strobe_cyc);
    int longest;
    longest = efuse_max(setup_cyc, strobe_cyc);
    return (longest <= 1) ? 1 : $clog2(longest);
  endfunction

endpackage

// File: rtl/lv_efuse_crc8.sv
// ---------------------------------------------------------------------------
// lv_efuse_crc8
//   Combinational CRC-8 step (poly 0x07, MSB first). Folds one efuse word of
//   DATA_W bits into the running CRC value. The running CRC register lives in
//   the instantiating block; this module holds no state.
//   Ports:
//     crc_in   [7:0]        current CRC value
//     data     [DATA_W-1:0] word to fold in, MSB processed first
//     crc_out  [7:0]        CRC after folding in data
//   Only compiled when macro LV_EFUSE_CRC_CHK_EN is defined.
// ---------------------------------------------------------------------------
`ifdef LV_EFUSE_CRC_CHK_EN
module lv_efuse_crc8
  import lv_efuse_load_ctrl_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [EFUSE_CRC_W-1:0] crc_in,
  input  logic [DATA_W-1:0]      data,
  output logic [EFUSE_CRC_W-1:0] crc_out
);

  logic [EFUSE_CRC_W-1:0] crc_var;
  logic                   fb;

  // Bit-serial LFSR unrolled over the word: the feedback bit is the CRC MSB
  // xor the incoming data bit, which is equivalent to the byte-wise
  // "xor then shift" form for 8-bit words but also works for other widths.
  always_comb begin
    crc_var = crc_in;
    fb      = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb      = crc_var[EFUSE_CRC_W-1] ^ data[i];
      crc_var = {crc_var[EFUSE_CRC_W-2:0], 1'b0} ^ (fb ? EFUSE_CRC8_POLY : 8'h00);
    end
    crc_out = crc_var;
  end

endmodule
`endif

// File: rtl/lv_efuse_load_ctrl.sv
// ---------------------------------------------------------------------------
// lv_efuse_load_ctrl
//   Efuse load sequencer sitting behind the LV control FSM. On a load request
//   (with the efuse-ctrl reg enable high) it reads EFUSE_WORD_NUM words from
//   the efuse macro using programmable setup/strobe timing and writes each
//   word into the LV reg bank, then returns a one-cycle done pulse.
//
//   Ports:
//     i_clk, i_rst_n         clock, asynchronous active-low reset
//     i_efuse_load_req       level request, held by the ctrl FSM until done
//     i_efuse_ctrl_reg_en    load permitted; low during a read aborts the load
//     o_efuse_load_done      one-cycle pulse when all words are written
//     o_efuse_load_busy      high from the first SETUP through DONE
//     o_efuse_load_err       CRC mismatch flag (0 when CRC check is not built)
//     o_efuse_csb            efuse chip select, active low
//     o_efuse_strobe         efuse read strobe
//     o_efuse_addr           efuse word address
//     i_efuse_rdata          efuse read data, valid on the last strobe cycle
//     o_efuse_reg_wr_en      reg bank write strobe
//     o_efuse_reg_waddr      reg bank word address
//     o_efuse_reg_wdata      reg bank write data
//
//   Build option: define LV_EFUSE_CRC_CHK_EN to check a CRC-8 over words
//   0..N-2 against word N-1; otherwise o_efuse_load_err is tied low.
//   All outputs are registered.
// ---------------------------------------------------------------------------
module lv_efuse_load_ctrl
  import lv_efuse_load_ctrl_pkg::*;
#(
  parameter int EFUSE_WORD_NUM = 8,
  parameter int EFUSE_ADDR_W   = 3,
  parameter int EFUSE_DATA_W   = 8,
  parameter int RD_SETUP_CYC   = 2,
  parameter int RD_STROBE_CYC  = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_efuse_load_req,
  input  logic                    i_efuse_ctrl_reg_en,
  output logic                    o_efuse_load_done,
  output logic                    o_efuse_load_busy,
  output logic                    o_efuse_load_err,
  output logic                    o_efuse_csb,
  output logic                    o_efuse_strobe,
  output logic [EFUSE_ADDR_W-1:0] o_efuse_addr,
  input  logic [EFUSE_DATA_W-1:0] i_efuse_rdata,
  output logic                    o_efuse_reg_wr_en,
  output logic [EFUSE_ADDR_W-1:0] o_efuse_reg_waddr,
  output logic [EFUSE_DATA_W-1:0] o_efuse_reg_wdata
);

  localparam int TMR_W = efuse_tmr_w(RD_SETUP_CYC, RD_STROBE_CYC);

  localparam logic [TMR_W-1:0]        SETUP_LOAD  = TMR_W'(RD_SETUP_CYC - 1);
  localparam logic [TMR_W-1:0]        STROBE_LOAD = TMR_W'(RD_STROBE_CYC - 1);
  localparam logic [EFUSE_ADDR_W-1:0] LAST_WORD   = EFUSE_ADDR_W'(EFUSE_WORD_NUM - 1);

  efuse_fsm_st_e             state_reg;
  logic [EFUSE_ADDR_W-1:0]   word_cnt_reg;
  logic [TMR_W-1:0]          tmr_reg;
  logic                      csb_reg;
  logic                      strobe_reg;
  logic [EFUSE_ADDR_W-1:0]   addr_reg;
  logic                      wr_en_reg;
  logic [EFUSE_ADDR_W-1:0]   waddr_reg;
  logic [EFUSE_DATA_W-1:0]   wdata_reg;
  logic                      done_reg;
  logic                      busy_reg;
  logic                      abort;

`ifdef LV_EFUSE_CRC_CHK_EN
  localparam int CMP_W = efuse_max(EFUSE_CRC_W, EFUSE_DATA_W);

  logic [EFUSE_CRC_W-1:0]    crc_reg;
  logic [EFUSE_CRC_W-1:0]    crc_next;
  logic                      err_reg;

  // Folds the word currently presented on the reg-bank write port into the
  // running CRC; used only in CAPTURE of words 0..N-2.
  lv_efuse_crc8 #(
    .DATA_W (EFUSE_DATA_W)
  ) u_crc8 (
    .crc_in  (crc_reg),
    .data    (wdata_reg),
    .crc_out (crc_next)
  );
`endif

  // Losing the reg enable only matters while the efuse is being accessed;
  // DONE/HOLD finish on their own.
  assign abort = !i_efuse_ctrl_reg_en &&
                 ((state_reg == EFUSE_SETUP_ST) ||
                  (state_reg == EFUSE_STROBE_ST) ||
                  (state_reg == EFUSE_CAPTURE_ST));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= EFUSE_IDLE_ST;
      word_cnt_reg <= '0;
      tmr_reg      <= '0;
      csb_reg      <= 1'b1;
      strobe_reg   <= 1'b0;
      addr_reg     <= '0;
      wr_en_reg    <= 1'b0;
      waddr_reg    <= '0;
      wdata_reg    <= '0;
      done_reg     <= 1'b0;
      busy_reg     <= 1'b0;
`ifdef LV_EFUSE_CRC_CHK_EN
      crc_reg      <= '0;
      err_reg      <= 1'b0;
`endif
    end else begin
      // Single-cycle pulses; re-asserted only by the branch that needs them.
      wr_en_reg <= 1'b0;
      done_reg  <= 1'b0;

      if (abort) begin
        // Drop the efuse interface at once; words already written stay in
        // the reg bank and the error flag is left alone.
        state_reg    <= EFUSE_IDLE_ST;
        word_cnt_reg <= '0;
        addr_reg     <= '0;
        csb_reg      <= 1'b1;
        strobe_reg   <= 1'b0;
        busy_reg     <= 1'b0;
      end else begin
        case (state_reg)
          EFUSE_IDLE_ST: begin
            if (i_efuse_load_req && i_efuse_ctrl_reg_en) begin
              state_reg    <= EFUSE_SETUP_ST;
              word_cnt_reg <= '0;
              addr_reg     <= '0;
              tmr_reg      <= SETUP_LOAD;
              csb_reg      <= 1'b0;
              strobe_reg   <= 1'b0;
              busy_reg     <= 1'b1;
`ifdef LV_EFUSE_CRC_CHK_EN
              crc_reg      <= '0;
              err_reg      <= 1'b0;
`endif
            end
          end

          EFUSE_SETUP_ST: begin
            if (tmr_reg == '0) begin
              state_reg  <= EFUSE_STROBE_ST;
              tmr_reg    <= STROBE_LOAD;
              strobe_reg <= 1'b1;
            end else begin
              tmr_reg <= tmr_reg - 1'b1;
            end
          end

          EFUSE_STROBE_ST: begin
            if (tmr_reg == '0) begin
              // Last strobe cycle: the macro output is valid now, so it is
              // captured straight into the reg-bank write data register.
              state_reg  <= EFUSE_CAPTURE_ST;
              strobe_reg <= 1'b0;
              wr_en_reg  <= 1'b1;
              waddr_reg  <= word_cnt_reg;
              wdata_reg  <= i_efuse_rdata;
            end else begin
              tmr_reg <= tmr_reg - 1'b1;
            end
          end

          EFUSE_CAPTURE_ST: begin
            if (word_cnt_reg == LAST_WORD) begin
              state_reg <= EFUSE_DONE_ST;
              csb_reg   <= 1'b1;
              done_reg  <= 1'b1;
`ifdef LV_EFUSE_CRC_CHK_EN
              // The final word carries the expected CRC of all earlier words.
              err_reg   <= (CMP_W'(crc_reg) != CMP_W'(wdata_reg));
`endif
            end else begin
              state_reg    <= EFUSE_SETUP_ST;
              word_cnt_reg <= word_cnt_reg + 1'b1;
              addr_reg     <= word_cnt_reg + 1'b1;
              tmr_reg      <= SETUP_LOAD;
`ifdef LV_EFUSE_CRC_CHK_EN
              crc_reg      <= crc_next;
`endif
            end
          end

          EFUSE_DONE_ST: begin
            state_reg <= EFUSE_HOLD_ST;
            busy_reg  <= 1'b0;
          end

          EFUSE_HOLD_ST: begin
            // The ctrl FSM still sees its own request for a few cycles after
            // done; waiting for it to fall prevents an immediate reload.
            if (!i_efuse_load_req) begin
              state_reg <= EFUSE_IDLE_ST;
            end
          end

          default: begin
            state_reg    <= EFUSE_IDLE_ST;
            word_cnt_reg <= '0;
            addr_reg     <= '0;
            csb_reg      <= 1'b1;
            strobe_reg   <= 1'b0;
            busy_reg     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_efuse_load_done = done_reg;
  assign o_efuse_load_busy = busy_reg;
  assign o_efuse_csb       = csb_reg;
  assign o_efuse_strobe    = strobe_reg;
  assign o_efuse_addr      = addr_reg;
  assign o_efuse_reg_wr_en = wr_en_reg;
  assign o_efuse_reg_waddr = waddr_reg;
  assign o_efuse_reg_wdata = wdata_reg;

`ifdef LV_EFUSE_CRC_CHK_EN
  assign o_efuse_load_err  = err_reg;
`else
  assign o_efuse_load_err  = 1'b0;
`endif

endmodule
